// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_pkg                                                      |
// | Description : Opcode constants, FSM state encoding and the shared carry    |
// |               rule for the accumulator ALU.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_pkg;

    // Legacy encodings 0-7 keep their original meaning; bit 3 selects the extended ops.
    localparam logic [3:0] OP_HLT = 4'd0;
    localparam logic [3:0] OP_SKZ = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LDA = 4'd5;
    localparam logic [3:0] OP_STO = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_SUB = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;
    localparam logic [3:0] OP_SHL = 4'd10;
    localparam logic [3:0] OP_SHR = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Selects which raw condition becomes the carry flag for a given opcode.
    function automatic logic carry_rule(
        input logic [3:0] op,
        input logic       add_cout,
        input logic       sub_borrow,
        input logic       a_msb,
        input logic       a_lsb,
        input logic       mul_hi
    );
        logic c;
        case (op)
            OP_ADD:  c = add_cout;
            OP_SUB:  c = sub_borrow;
            OP_SHL:  c = a_msb;
            OP_SHR:  c = a_lsb;
            OP_MUL:  c = mul_hi;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_acc_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_acc_seq_if                                               |
// | Description : Request/response handshake bundle between decode, the ALU   |
// |               and the accumulator register.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface alu_acc_seq_if #(
    parameter int WIDTH    = 8,
    parameter int OPCODE_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] opcode;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    alu_out;
    logic                a_is_zero;
    logic                carry;
    logic                negative;

    // Requester side: issues operations and consumes results.
    modport master (
        output in_valid, opcode, in_a, in_b, out_ready,
        input  in_ready, out_valid, alu_out, a_is_zero, carry, negative
    );

    // ALU side.
    modport slave (
        input  in_valid, opcode, in_a, in_b, out_ready,
        output in_ready, out_valid, alu_out, a_is_zero, carry, negative
    );
endinterface
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_mul_iter                                                 |
// | Description : Shift-add multiplier, one multiplier bit per cycle over      |
// |               WIDTH cycles. done is high in the final cycle, when product  |
// |               already includes the last partial product.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    input  wire logic [WIDTH-1:0]   a,
    input  wire logic [WIDTH-1:0]   b,
    output logic                    done,
    output logic [2*WIDTH-1:0]      product
);
    localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic                 r_busy;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   w_prod_next;

    // Final partial product is folded in combinationally so the caller can
    // register the result on the same edge as the last iteration.
    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign done        = r_busy && (r_cnt == c_LAST);
    assign product     = w_prod_next;

    // Operand capture on start, then one shift-add step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_prod   <= '0;
        end else if (r_busy) begin
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_acc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_acc_seq                                                  |
// | Description : Registered, handshaked accumulator ALU. Single-cycle ops     |
// |               load the output register on accept; MUL (when the macro      |
// |               ALU_ACC_MUL_EN is defined) runs through alu_mul_iter.        |
// |               Without ALU_ACC_MUL_EN opcode 12 is a single-cycle pass A.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_acc_seq #(
    parameter int WIDTH    = 8,
    parameter int OPCODE_W = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alu_acc_seq_if.slave bus
);
    import alu_pkg::*;

    state_t            r_state;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_alu_out;
    logic              r_a_zero;
    logic              r_carry;
    logic              r_neg;

    logic [3:0]        w_op;
    logic [WIDTH:0]    w_add;
    logic [WIDTH:0]    w_sub;
    logic [WIDTH-1:0]  w_res;
    logic              w_carry;
    logic              w_accept;
    logic              w_is_mul;

    // Opcodes outside the 4-bit table collapse to HLT, which routes to pass A.
    generate
        if (OPCODE_W > 4) begin : g_op_wide
            assign w_op = (bus.opcode[OPCODE_W-1:4] == '0) ? bus.opcode[3:0] : OP_HLT;
        end else begin : g_op_exact
            assign w_op = bus.opcode[3:0];
        end
    endgenerate

    assign bus.in_ready = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;

`ifdef ALU_ACC_MUL_EN
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_mul_prod;
    logic                 r_mul_a_zero;

    assign w_is_mul = (w_op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_accept && w_is_mul),
        .a       (bus.in_a),
        .b       (bus.in_b),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );

    // The zero flag refers to the operand, so remember it until the product lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_a_zero <= 1'b0;
        end else if (w_accept && w_is_mul) begin
            r_mul_a_zero <= (bus.in_a == '0);
        end
    end
`else
    assign w_is_mul = 1'b0;
`endif

    // Single-cycle datapath; anything unrecognised passes A through.
    always_comb begin
        w_add = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        w_sub = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        w_res = bus.in_a;
        case (w_op)
            OP_ADD:                         w_res = w_add[WIDTH-1:0];
            OP_AND:                         w_res = bus.in_a & bus.in_b;
            OP_XOR:                         w_res = bus.in_a ^ bus.in_b;
            OP_LDA:                         w_res = bus.in_b;
            OP_SUB:                         w_res = w_sub[WIDTH-1:0];
            OP_OR:                          w_res = bus.in_a | bus.in_b;
            OP_SHL:                         w_res = {bus.in_a[WIDTH-2:0], 1'b0};
            OP_SHR:                         w_res = {1'b0, bus.in_a[WIDTH-1:1]};
            OP_HLT, OP_SKZ, OP_STO, OP_JMP: w_res = bus.in_a;
            default:                        w_res = bus.in_a;
        endcase
        w_carry = carry_rule(w_op, w_add[WIDTH], w_sub[WIDTH],
                             bus.in_a[WIDTH-1], bus.in_a[0], 1'b0);
    end

    // Control FSM and output register; a drained slot can be refilled on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_a_zero    <= 1'b0;
            r_carry     <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state     <= ST_MUL;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_alu_out   <= w_res;
                            r_a_zero    <= (bus.in_a == '0);
                            r_carry     <= w_carry;
                            r_neg       <= w_res[WIDTH-1];
                        end
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
`ifdef ALU_ACC_MUL_EN
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b1;
                        r_alu_out   <= w_mul_prod[WIDTH-1:0];
                        r_a_zero    <= r_mul_a_zero;
                        r_carry     <= carry_rule(OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0,
                                                  |w_mul_prod[2*WIDTH-1:WIDTH]);
                        r_neg       <= w_mul_prod[WIDTH-1];
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.alu_out   = r_alu_out;
    assign bus.a_is_zero = r_a_zero;
    assign bus.carry     = r_carry;
    assign bus.negative  = r_neg;
endmodule
`default_nettype wire

// File: tb/tb_alu_acc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_acc_seq                                               |
// | Description : Self-checking bench for alu_acc_seq: directed cases plus     |
// |               randomized operations against an arithmetic reference.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_acc_seq;
    localparam int WIDTH    = 8;
    localparam int OPCODE_W = 4;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    alu_acc_seq_if #(.WIDTH(WIDTH), .OPCODE_W(OPCODE_W)) bus ();

    alu_acc_seq #(.WIDTH(WIDTH), .OPCODE_W(OPCODE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode table.
    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int res, output int cy, output int lat);
        int m;
        m   = 1 << WIDTH;
        cy  = 0;
        lat = 1;
        case (op)
            2:  begin res = a + b; cy = (res >= m) ? 1 : 0; end
            3:  res = a & b;
            4:  res = a ^ b;
            5:  res = b;
            8:  begin res = a - b; cy = (a < b) ? 1 : 0; end
            9:  res = a | b;
            10: begin res = a * 2; cy = (a >= m / 2) ? 1 : 0; end
            11: begin res = a / 2; cy = a % 2; end
`ifdef ALU_ACC_MUL_EN
            12: begin res = a * b; cy = (res >= m) ? 1 : 0; lat = WIDTH + 1; end
`endif
            default: res = a;
        endcase
        res = ((res % m) + m) % m;
    endfunction

    // Issue one op, measure latency, check result and flags, then drain it.
    task automatic run_op(input string tag, input int op, input int a, input int b, input int hold);
        int exp_res, exp_cy, exp_lat, lat, waitc;
        ref_alu(op, a, b, exp_res, exp_cy, exp_lat);
        @(negedge clk);
        bus.opcode   = OPCODE_W'(op);
        bus.in_a     = WIDTH'(a);
        bus.in_b     = WIDTH'(b);
        bus.in_valid = 1'b1;
        waitc = 0;
        while (!bus.in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) check_val({tag, "_ready_timeout"}, 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (exp_lat > 1 && !bus.out_valid) check_val({tag, "_busy_in_ready"}, bus.in_ready, 0);
        end while (!bus.out_valid && lat < 30);
        check_val({tag, "_latency"}, lat, exp_lat);
        check_val({tag, "_res"}, bus.alu_out, exp_res);
        check_val({tag, "_carry"}, bus.carry, exp_cy);
        check_val({tag, "_neg"}, bus.negative, (exp_res >= (1 << (WIDTH - 1))) ? 1 : 0);
        check_val({tag, "_azero"}, bus.a_is_zero, (a == 0) ? 1 : 0);
        repeat (hold) @(negedge clk);
        if (hold > 0) check_val({tag, "_held"}, bus.alu_out, exp_res);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check_val({tag, "_drained"}, bus.out_valid, 0);
    endtask

    initial begin
        int seen;
        n_total       = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.opcode    = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_alu_out", bus.alu_out, 0);
        check_val("rst_flags", {bus.a_is_zero, bus.carry, bus.negative}, 0);
        check_val("rst_in_ready", bus.in_ready, 1);

        run_op("add1", 2, 8'h42, 8'h86, 0);
        run_op("add2", 2, 8'hFF, 8'h01, 0);
        run_op("sub",  8, 8'h42, 8'h86, 0);
        run_op("op7z", 7, 8'h00, 8'h55, 0);
        run_op("mul1", 12, 8'h0F, 8'h11, 0);
        run_op("mul2", 12, 8'h10, 8'h10, 0);
        run_op("shl",  10, 8'h81, 8'h00, 0);
        run_op("shr",  11, 8'h81, 8'h00, 0);
        run_op("or",   9, 8'h42, 8'h86, 0);

        // Backpressure, then accept-and-drain in the same cycle.
        @(negedge clk);
        bus.opcode = 4'd4; bus.in_a = 8'h42; bus.in_b = 8'h86; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_valid", bus.out_valid, 1);
            check_val("bp_hold", bus.alu_out, 8'hC4);
            check_val("bp_in_ready", bus.in_ready, 0);
        end
        bus.opcode = 4'd3; bus.in_a = 8'h42; bus.in_b = 8'h86; bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1 check_val("bp_ready_on_drain", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check_val("bp_nobubble", bus.out_valid, 1);
        check_val("bp_and", bus.alu_out, 8'h02);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check_val("bp_drained", bus.out_valid, 0);

        // Asynchronous reset in the middle of a multiply.
        run_op("pre_rst", 2, 8'h42, 8'h86, 0);
        @(negedge clk);
        bus.opcode = 4'd12; bus.in_a = 8'h0F; bus.in_b = 8'h11; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_valid", bus.out_valid, 0);
        check_val("arst_out", bus.alu_out, 0);
        check_val("arst_flags", {bus.a_is_zero, bus.carry, bus.negative}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("arst_in_ready", bus.in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check_val("arst_no_stale", seen, 0);

        // Randomized operations.
        for (int i = 0; i < 150; i++) begin
            run_op("rnd", int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Absolute safety net against a stuck run.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
